// File: rtl/vc_demux_buf_sec_if.sv
// Handshake bundle for vc_demux_buf_sec: one val/rdy input stream with a
// destination select, and p_nout val/rdy output channels packed side by side.
interface vc_demux_buf_sec_if #(
    parameter int p_nbits     = 32,
    parameter int p_nout      = 4,
    parameter int p_sel_nbits = 2
);
    logic                       in_val;
    logic                       in_rdy;
    logic [p_nbits-1:0]         in_msg;
    logic [p_sel_nbits-1:0]     in_sel;
    logic [p_nout-1:0]          out_val;
    logic [p_nout-1:0]          out_rdy;
    logic [p_nout*p_nbits-1:0]  out_msg;

    modport master (
        output in_val, in_msg, in_sel, out_rdy,
        input  in_rdy, out_val, out_msg
    );

    modport slave (
        input  in_val, in_msg, in_sel, out_rdy,
        output in_rdy, out_val, out_msg
    );
endinterface

// File: rtl/vc_demux_buf_sec.sv
// Buffered 1-to-N demux with a 2-entry FIFO per output channel.
// Optional VC_DEMUX_BUF_SCRUB_EN: flush all FIFOs whenever the security domain sd changes.
module vc_demux_buf_sec #(
    parameter int p_nbits     = 32,
    parameter int p_nout      = 4,
    parameter int p_sel_nbits = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sd,
    vc_demux_buf_sec_if.slave bus,
    output logic              err_sel
);

    logic [1:0]         count_p1 [p_nout];
    logic               head_p1  [p_nout];
    logic               tail_p1  [p_nout];
    logic [p_nbits-1:0] mem_p1   [p_nout][2];
    logic               err_p1;

    logic               sel_legal;
    logic               sel_full;
    logic               accept;
    logic               scrub;
    logic [p_nout-1:0]  enq;
    logic [p_nout-1:0]  deq;

`ifdef VC_DEMUX_BUF_SCRUB_EN
    logic sd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sd_q <= 1'b0;
        else          sd_q <= sd;
    end

    assign scrub = (sd != sd_q);
`else
    logic unused_sd;
    assign unused_sd = sd;
    assign scrub     = 1'b0;
`endif

    // Decode in_sel by matching each channel index so out-of-range selects never index the arrays.
    always_comb begin
        sel_legal = 1'b0;
        sel_full  = 1'b0;
        for (int i = 0; i < p_nout; i++) begin
            if (bus.in_sel == p_sel_nbits'(i)) begin
                sel_legal = 1'b1;
                sel_full  = (count_p1[i] == 2'd2);
            end
        end
    end

    assign bus.in_rdy = !scrub && (!sel_legal || !sel_full);
    assign accept     = bus.in_val && bus.in_rdy;

    always_comb begin
        enq         = '0;
        deq         = '0;
        bus.out_val = '0;
        bus.out_msg = '0;
        for (int i = 0; i < p_nout; i++) begin
            enq[i]         = accept && (bus.in_sel == p_sel_nbits'(i));
            deq[i]         = (count_p1[i] != 2'd0) && bus.out_rdy[i];
            bus.out_val[i] = (count_p1[i] != 2'd0);
            if (count_p1[i] != 2'd0)
                bus.out_msg[i*p_nbits +: p_nbits] = mem_p1[i][head_p1[i]];
        end
    end

    // Stage p1: FIFO control state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_p1 <= 1'b0;
            for (int i = 0; i < p_nout; i++) begin
                count_p1[i] <= 2'd0;
                head_p1[i]  <= 1'b0;
                tail_p1[i]  <= 1'b0;
            end
        end else begin
            err_p1 <= accept && !sel_legal;
            for (int i = 0; i < p_nout; i++) begin
                if (scrub) begin
                    count_p1[i] <= 2'd0;
                    head_p1[i]  <= 1'b0;
                    tail_p1[i]  <= 1'b0;
                end else begin
                    if (enq[i]) tail_p1[i] <= !tail_p1[i];
                    if (deq[i]) head_p1[i] <= !head_p1[i];
                    case ({enq[i], deq[i]})
                        2'b10:   count_p1[i] <= count_p1[i] + 2'd1;
                        2'b01:   count_p1[i] <= count_p1[i] - 2'd1;
                        default: count_p1[i] <= count_p1[i];
                    endcase
                end
            end
        end
    end

    // Stage p1: FIFO storage; contents are masked by count, so reset is not needed here
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_nout; i++) begin
            if (scrub) begin
                mem_p1[i][0] <= '0;
                mem_p1[i][1] <= '0;
            end else if (enq[i]) begin
                mem_p1[i][tail_p1[i]] <= bus.in_msg;
            end
        end
    end

    assign err_sel = err_p1;

endmodule
